// File: rtl/doa_pkg.sv
// rtl/doa_pkg.sv - shared types and constants for the DOA frame sequencer
package doa_pkg;

  localparam int ADDR_W = 10;

  typedef logic signed [7:0] doa_angle_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_FFT,
    ST_DETECT,
    ST_BEAM,
    ST_PUBLISH,
    ST_GAP
  } seq_state_t;

  // Stages that hand off to a sub-block and wait for its done.
  function automatic logic is_working(seq_state_t s);
    return (s == ST_CAPTURE) || (s == ST_FFT) || (s == ST_DETECT) || (s == ST_BEAM);
  endfunction

endpackage

// File: rtl/doa_frame_sequencer_stage_timer.sv
// rtl/doa_frame_sequencer_stage_timer.sv - loadable down-counter with expiry flag (GAP count, stage watchdog)
module stage_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/doa_frame_sequencer.sv
// rtl/doa_frame_sequencer.sv - DOA frame scheduler: stage handshakes, shared FFT RAM address, publish
// Optional per-stage watchdog enabled by defining SEQ_WATCHDOG_EN.
module doa_frame_sequencer
  import doa_pkg::*;
#(
  parameter int ADDR_W      = doa_pkg::ADDR_W,
  parameter int GAP_CYC     = 16,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              single,
  output logic              cap_start,
  input  logic              cap_done,
  output logic              fft_start,
  input  logic              fft_done,
  output logic              fd_start,
  input  logic              fd_done,
  input  logic [ADDR_W-1:0] fd_rdaddr,
  input  logic [ADDR_W-1:0] fd_maxbin,
  output logic              bf_start,
  input  logic              bf_done,
  input  logic signed [7:0] bf_doa,
  output logic [ADDR_W-1:0] ram_rdaddr,
  output logic [ADDR_W-1:0] maxbin,
  output logic signed [7:0] doa,
  output logic              doa_valid,
  output logic [15:0]       frame_cnt,
  output logic              busy,
  output logic              err
);

  // GAP lasts max(GAP_CYC,1) cycles; the timer is loaded as GAP is entered.
  localparam logic [15:0] GAP_LOAD = (GAP_CYC == 0) ? 16'd0 : 16'(GAP_CYC - 1);

  seq_state_t state;
  doa_angle_t doa_hold;
  logic       in_start;
  logic       done_now;
  logic       stage_timeout;
  logic       gap_load;
  logic       gap_expired;

  assign in_start = cap_start | fft_start | fd_start | bf_start;

  always_comb begin
    done_now = 1'b0;
    case (state)
      ST_CAPTURE: done_now = cap_done;
      ST_FFT:     done_now = fft_done;
      ST_DETECT:  done_now = fd_done;
      ST_BEAM:    done_now = bf_done;
      default:    done_now = 1'b0;
    endcase
  end

  // The detector owns the RAM address only while scanning; beam search reads the peak bin.
  assign ram_rdaddr = (state == ST_DETECT) ? fd_rdaddr : maxbin;
  assign busy       = (state != ST_IDLE);
  assign gap_load   = (state == ST_PUBLISH);

  stage_timer #(.W(16)) u_gap_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (gap_load),
    .load_val (GAP_LOAD),
    .expired  (gap_expired)
  );

`ifdef SEQ_WATCHDOG_EN
  // Loaded in the start cycle, so it reaches zero on the TIMEOUT_CYC-th cycle of the stage.
  localparam logic [15:0] WD_LOAD = (TIMEOUT_CYC >= 2) ? 16'(TIMEOUT_CYC - 2) : 16'd0;

  logic wd_expired;
  logic err_q;

  stage_timer #(.W(16)) u_wd_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (in_start),
    .load_val (WD_LOAD),
    .expired  (wd_expired)
  );

  assign stage_timeout = is_working(state) && !in_start && !done_now && wd_expired;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (stage_timeout) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign stage_timeout = 1'b0;
  assign err           = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cap_start <= 1'b0;
      fft_start <= 1'b0;
      fd_start  <= 1'b0;
      bf_start  <= 1'b0;
      doa_valid <= 1'b0;
      doa       <= '0;
      doa_hold  <= '0;
      maxbin    <= '0;
      frame_cnt <= '0;
    end else begin
      cap_start <= 1'b0;
      fft_start <= 1'b0;
      fd_start  <= 1'b0;
      bf_start  <= 1'b0;
      doa_valid <= 1'b0;
      if (stage_timeout) begin
        state <= ST_IDLE;
      end else begin
        // Done inputs are ignored in a stage's start cycle.
        case (state)
          ST_IDLE: begin
            if (run || single) begin
              state     <= ST_CAPTURE;
              cap_start <= 1'b1;
            end
          end
          ST_CAPTURE: begin
            if (!in_start && done_now) begin
              state     <= ST_FFT;
              fft_start <= 1'b1;
            end
          end
          ST_FFT: begin
            if (!in_start && done_now) begin
              state    <= ST_DETECT;
              fd_start <= 1'b1;
            end
          end
          ST_DETECT: begin
            if (!in_start && done_now) begin
              maxbin   <= fd_maxbin;
              state    <= ST_BEAM;
              bf_start <= 1'b1;
            end
          end
          ST_BEAM: begin
            if (!in_start && done_now) begin
              doa_hold <= bf_doa;
              state    <= ST_PUBLISH;
            end
          end
          ST_PUBLISH: begin
            doa       <= doa_hold;
            doa_valid <= 1'b1;
            frame_cnt <= frame_cnt + 16'd1;
            state     <= ST_GAP;
          end
          ST_GAP: begin
            if (gap_expired) begin
              if (run) begin
                state     <= ST_CAPTURE;
                cap_start <= 1'b1;
              end else begin
                state <= ST_IDLE;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_doa_frame_sequencer.sv
// tb/tb_doa_frame_sequencer.sv - self-checking bench for doa_frame_sequencer (honours SEQ_WATCHDOG_EN)
module tb_doa_frame_sequencer;

  localparam int ADDR_W      = 10;
  localparam int GAP_CYC     = 16;
  localparam int TIMEOUT_CYC = 100;
`ifdef SEQ_WATCHDOG_EN
  localparam int SWEEP_N = 90;
`else
  localparam int SWEEP_N = 1024;
`endif

  logic clk = 1'b0;
  logic reset, run, single;
  logic cap_start, cap_done, fft_start, fft_done, fd_start, fd_done, bf_start, bf_done;
  logic [ADDR_W-1:0] fd_rdaddr, fd_maxbin, ram_rdaddr, maxbin;
  logic [7:0] bf_doa, doa;
  logic doa_valid, busy, err;
  logic [15:0] frame_cnt;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int cap_cnt = 0;
  int last_cap_cyc = 0;
  int last_valid_cyc = 0;

  typedef struct {
    logic [ADDR_W-1:0] mb;
    int                ang;
    logic [7:0]        exp_doa;
    logic [15:0]       exp_cnt;
    bit                sweep;
    bit                spurious;
  } frame_vec_t;

  frame_vec_t single_vecs[3];
  frame_vec_t run_vecs[3];

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (doa_valid) valid_cnt++;
    if (cap_start) cap_cnt++;
  end

  doa_frame_sequencer #(
    .ADDR_W      (ADDR_W),
    .GAP_CYC     (GAP_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .single     (single),
    .cap_start  (cap_start),
    .cap_done   (cap_done),
    .fft_start  (fft_start),
    .fft_done   (fft_done),
    .fd_start   (fd_start),
    .fd_done    (fd_done),
    .fd_rdaddr  (fd_rdaddr),
    .fd_maxbin  (fd_maxbin),
    .bf_start   (bf_start),
    .bf_done    (bf_done),
    .bf_doa     (bf_doa),
    .ram_rdaddr (ram_rdaddr),
    .maxbin     (maxbin),
    .doa        (doa),
    .doa_valid  (doa_valid),
    .frame_cnt  (frame_cnt),
    .busy       (busy),
    .err        (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic start_of(input int s);
    case (s)
      0:       return cap_start;
      1:       return fft_start;
      2:       return fd_start;
      default: return bf_start;
    endcase
  endfunction

  task automatic set_done(input int s, input logic v);
    case (s)
      0:       cap_done = v;
      1:       fft_done = v;
      2:       fd_done  = v;
      default: bf_done  = v;
    endcase
  endtask

  task automatic wait_start(input int s, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (start_of(s)) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check($sformatf("start_seen_stage%0d", s), ok, 1);
  endtask

  task automatic respond(input int s);
    repeat (5) tick();
    set_done(s, 1'b1);
    tick();
    set_done(s, 1'b0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_cap_start"}, cap_start, 0);
    check({tag, "_fft_start"}, fft_start, 0);
    check({tag, "_fd_start"}, fd_start, 0);
    check({tag, "_bf_start"}, bf_start, 0);
    check({tag, "_doa_valid"}, doa_valid, 0);
    check({tag, "_doa"}, doa, 0);
    check({tag, "_maxbin"}, maxbin, 0);
    check({tag, "_ram_rdaddr"}, ram_rdaddr, 0);
    check({tag, "_frame_cnt"}, frame_cnt, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err"}, err, 0);
  endtask

  task automatic do_frame(input frame_vec_t v, input bit drop_run, input bit reset_in_beam);
    bit ok;
    int errs;
    int n;
    wait_start(0, ok);
    if (!ok) return;
    last_cap_cyc = cyc;
    respond(0);

    wait_start(1, ok);
    if (!ok) return;
    if (v.spurious) begin
      fft_done = 1'b1;
      bf_done  = 1'b1;
      tick();
      fft_done = 1'b0;
      bf_done  = 1'b0;
      check("fft_done_in_start_ignored", fd_start, 0);
      bf_done = 1'b1;
      repeat (2) tick();
      bf_done = 1'b0;
      check("bf_done_in_fft_ignored", fd_start | bf_start, 0);
      check("fft_still_busy", busy, 1);
    end
    respond(1);

    wait_start(2, ok);
    if (!ok) return;
    fd_maxbin = v.mb;
    if (v.sweep) begin
      errs = 0;
      for (int a = 0; a < SWEEP_N; a++) begin
        fd_rdaddr = 10'(a);
        #1;
        if (ram_rdaddr !== 10'(a)) errs++;
        tick();
      end
      check("detect_sweep_errs", errs, 0);
    end else begin
      fd_rdaddr = 10'h2C5;
      #1;
      check("detect_passthru", ram_rdaddr, 10'h2C5);
    end
    if (v.spurious) begin
      bf_done = 1'b1;
      tick();
      bf_done = 1'b0;
      check("bf_done_in_detect_ignored", bf_start, 0);
      check("still_detect_mux", ram_rdaddr, fd_rdaddr);
    end
    respond(2);

    wait_start(3, ok);
    if (!ok) return;
    fd_rdaddr = ~v.mb;
    check("maxbin_latched", maxbin, v.mb);
    if (drop_run) run = 1'b0;
    if (reset_in_beam) begin
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_reset_state("beam_reset");
      n = valid_cnt;
      repeat (10) tick();
      check("no_valid_after_reset", valid_cnt, n);
      check("idle_after_reset", busy, 0);
      return;
    end
    errs = 0;
    for (int i = 0; i < 5; i++) begin
      if (ram_rdaddr !== v.mb) errs++;
      tick();
    end
    check("beam_rdaddr_errs", errs, 0);
    bf_doa  = 8'(v.ang);
    bf_done = 1'b1;
    tick();
    bf_done = 1'b0;
    bf_doa  = 8'h11;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (doa_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check("doa_valid_seen", ok, 1);
    last_valid_cyc = cyc;
    check("doa", doa, v.exp_doa);
    check("frame_cnt", frame_cnt, v.exp_cnt);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    bit ok;
    int n;
    int prev_valid;
    frame_vec_t dummy;

    single_vecs[0] = '{10'h1A3, -35, 8'hDD, 16'd1, 1'b1, 1'b0};
    single_vecs[1] = '{10'h3FF,  90, 8'h5A, 16'd2, 1'b0, 1'b1};
    single_vecs[2] = '{10'h000, -90, 8'hA6, 16'd3, 1'b0, 1'b0};
    run_vecs[0]    = '{10'h155,   1, 8'h01, 16'd4, 1'b0, 1'b0};
    run_vecs[1]    = '{10'h2AA,  45, 8'h2D, 16'd5, 1'b0, 1'b0};
    run_vecs[2]    = '{10'h07F,  -1, 8'hFF, 16'd6, 1'b0, 1'b1};
    dummy          = '{10'h1A3, -35, 8'hDD, 16'd1, 1'b0, 1'b0};

    reset = 1'b1; run = 1'b0; single = 1'b0;
    cap_done = 1'b0; fft_done = 1'b0; fd_done = 1'b0; bf_done = 1'b0;
    fd_rdaddr = '0; fd_maxbin = '0; bf_doa = '0;
    repeat (3) tick();
    check_reset_state("por");
    reset = 1'b0;
    tick();
    check("idle_no_start", cap_start, 0);

    for (int i = 0; i < 3; i++) begin
      single = 1'b1;
      tick();
      single = 1'b0;
      do_frame(single_vecs[i], 1'b0, 1'b0);
      single = 1'b1;
      tick();
      single = 1'b0;
      repeat (GAP_CYC + 4) tick();
      check("single_back_idle", busy, 0);
      check("single_cap_count", cap_cnt, i + 1);
      check("single_valid_count", valid_cnt, i + 1);
      check("idle_rdaddr_maxbin", ram_rdaddr, single_vecs[i].mb);
    end

    run = 1'b1;
    for (int i = 0; i < 3; i++) begin
      prev_valid = last_valid_cyc;
      do_frame(run_vecs[i], i == 2, 1'b0);
      if (i > 0) check("gap_cycles", last_cap_cyc - prev_valid, GAP_CYC);
    end
    repeat (GAP_CYC + 4) tick();
    check("run_drop_idle", busy, 0);
    check("run_valid_count", valid_cnt, 6);
    check("run_cap_count", cap_cnt, 6);

    single = 1'b1;
    tick();
    single = 1'b0;
    do_frame(dummy, 1'b0, 1'b1);

    n = valid_cnt;
    single = 1'b1;
    tick();
    single = 1'b0;
    wait_start(0, ok);
    respond(0);
    wait_start(1, ok);
`ifdef SEQ_WATCHDOG_EN
    begin
      int k;
      k = 0;
      while (!err && k < 300) begin
        tick();
        k++;
      end
      check("wd_cycles", k, TIMEOUT_CYC);
      check("wd_err", err, 1);
      check("wd_idle", busy, 0);
      check("wd_frame_cnt", frame_cnt, 0);
    end
`else
    repeat (300) tick();
    check("stall_err", err, 0);
    check("stall_busy", busy, 1);
`endif
    check("stall_no_publish", valid_cnt, n);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("final_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
